// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op encodings, data width,
// condition-code reset values and the response-slot states.
package alu_arbiter_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  localparam logic CC_ZF_RST = 1'b1;
  localparam logic CC_SF_RST = 1'b0;
  localparam logic CC_OF_RST = 1'b0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request channel of one ALU requester: valid/ready handshake plus operation fields.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic              valid;
  logic              ready;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              setcc;

  modport master (output valid, op, a, b, setcc, input ready);
  modport slave  (input valid, op, a, b, setcc, output ready);

endinterface

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU: add/sub with signed overflow, and/xor with overflow forced low.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  // Operation select; overflow compares operand signs against the result sign.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (sel)
      OP_ADD: begin
        result   = a + b + {{(DATA_W-1){1'b0}}, cin};
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        result   = a - b - {{(DATA_W-1){1'b0}}, cin};
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: begin
        result   = a & b;
        overflow = 1'b0;
      end
      OP_XOR: begin
        result   = a ^ b;
        overflow = 1'b0;
      end
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding one shared ALU into a single-entry response slot,
// with architectural condition codes updated on accepted setcc requests.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      req0,
  alu_arbiter_if.slave      req1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_ovf,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of
);

  slot_state_e       state_r, state_s;
  logic              last_r;
  logic              rsp_id_r, rsp_ovf_r;
  logic [DATA_W-1:0] rsp_result_r;
  logic              cc_zf_r, cc_sf_r, cc_of_r;

  logic              slot_free_s, gnt_s, accept_s, setcc_s;
  logic [1:0]        op_s;
  logic [DATA_W-1:0] a_s, b_s, alu_result_s;
  logic              alu_ovf_s;

  // Grant: readiness depends only on valids, slot occupancy and the round-robin pointer.
  always_comb begin
    slot_free_s = 1'b0;
    gnt_s       = 1'b0;
    if (rst_n) begin
      slot_free_s = (state_r == ST_EMPTY) || rsp_ready;
    end else begin
      slot_free_s = 1'b0;
    end
    case ({req1.valid, req0.valid})
      2'b01:   gnt_s = 1'b0;
      2'b10:   gnt_s = 1'b1;
      2'b11:   gnt_s = ~last_r;
      default: gnt_s = 1'b0;
    endcase
    accept_s   = slot_free_s && (req0.valid || req1.valid);
    req0.ready = accept_s && !gnt_s;
    req1.ready = accept_s && gnt_s;
  end

  // Operand mux in front of the shared ALU.
  always_comb begin
    op_s    = req0.op;
    a_s     = req0.a;
    b_s     = req0.b;
    setcc_s = req0.setcc;
    if (gnt_s) begin
      op_s    = req1.op;
      a_s     = req1.a;
      b_s     = req1.b;
      setcc_s = req1.setcc;
    end else begin
      op_s    = req0.op;
      a_s     = req0.a;
      b_s     = req0.b;
      setcc_s = req0.setcc;
    end
  end

  alu u_alu (
    .sel      (op_s),
    .a        (a_s),
    .b        (b_s),
    .cin      (1'b0),
    .result   (alu_result_s),
    .overflow (alu_ovf_s)
  );

  // Slot next state: an accept always fills it, a drain without accept empties it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) state_s = ST_FULL;
        else          state_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (accept_s)       state_s = ST_FULL;
        else if (rsp_ready) state_s = ST_EMPTY;
        else                state_s = ST_FULL;
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_EMPTY;
    else        state_r <= state_s;
  end

  // Response capture, pointer and condition codes; pointer resets so FIRST_PRIO wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r       <= ~FIRST_PRIO;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= '0;
      rsp_ovf_r    <= 1'b0;
      cc_zf_r      <= CC_ZF_RST;
      cc_sf_r      <= CC_SF_RST;
      cc_of_r      <= CC_OF_RST;
    end else if (accept_s) begin
      last_r       <= gnt_s;
      rsp_id_r     <= gnt_s;
      rsp_result_r <= alu_result_s;
      rsp_ovf_r    <= alu_ovf_s;
      if (setcc_s) begin
        cc_zf_r <= (alu_result_s == '0);
        cc_sf_r <= alu_result_s[DATA_W-1];
        cc_of_r <= alu_ovf_s;
      end
    end
  end

  assign rsp_valid  = (state_r == ST_FULL);
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_ovf    = rsp_ovf_r;
  assign cc_zf      = cc_zf_r;
  assign cc_sf      = cc_sf_r;
  assign cc_of      = cc_of_r;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIRST_PRIO, default 0, which requester wins the first contended cycle after reset (0 or 1).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 Ports (each of req0_*, req1_*): _valid in 1, request present; _ready out 1, request accepted this cycle; _op in 2, ALU select (00 add, 01 sub, 10 and, 11 xor); _a in 64, operand a; _b in 64, operand b; _setcc in 1, update condition codes on completion.
REQ-005 Port: rsp_valid  out  1  response slot holds a result.
REQ-006 Port: rsp_ready  in  1  consumer takes the response this cycle.
REQ-007 Port: rsp_id  out  1  requester that issued the response.
REQ-008 Port: rsp_result  out  64  ALU result.
REQ-009 Port: rsp_ovf  out  1  ALU overflow flag (0 for and/xor).
REQ-010 Port: cc_zf, cc_sf, cc_of  out  1 each  architectural condition codes.

Function
REQ-011 Accept: a request transfers when _valid and _ready are both 1 on the same edge; at most one requester is readied per cycle.
REQ-012 Readiness: _ready depends only on the valid inputs and internal state, never on _op/_a/_b; slot free = !rsp_valid or rsp_ready.
REQ-013 Grant: slot free and exactly one valid -> that requester readied; both valid -> requester not granted last is readied (round-robin); the pointer updates only on an accepted transfer.
REQ-014 Latency: accept at edge N -> rsp_valid=1 with rsp_id, rsp_result, rsp_ovf after edge N; exactly one cycle; throughput one per cycle while rsp_ready=1.
REQ-015 Result: rsp_result/rsp_ovf equal the shared ALU outputs for the accepted op, a, b, captured at the accept edge.
REQ-016 Hold: rsp_valid=1 and rsp_ready=0 -> rsp_* stable, both _ready=0.
REQ-017 Drain: rsp_valid=1, rsp_ready=1, no new accept -> rsp_valid=0 after the edge.
REQ-018 Simultaneous drain and accept: the slot is overwritten with the new result; rsp_valid stays 1 and no cycle is lost.
REQ-019 Condition codes: update at the accept edge only when _setcc=1; ZF = (result==0), SF = result[63], OF = ALU overflow; otherwise hold.
REQ-020 States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on hold or drain+accept.
REQ-021 Idle: no valid requests -> no state change except drain.

Reset
REQ-022 rst_n=0 at an edge -> rsp_valid=0, rsp_id=0, rsp_result=0, rsp_ovf=0, cc_zf=1, cc_sf=0, cc_of=0, pointer such that FIRST_PRIO wins next.
REQ-023 _ready=0 for both requesters while rst_n=0.
REQ-024 Reset mid-operation discards any held response and any same-cycle request; no cc update in that cycle.

Structure
REQ-025 Shared package holds the ALU op encodings (ADD=00, SUB=01, AND=10, XOR=11), the 64-bit data width constant and the cc reset values.
REQ-026 Exactly one instance of the existing alu module (sel, a, b, cin tied 0, result, overflow), fed by the grant-selected operand mux; no other sub-modules.

Verification
REQ-027 req0 add a=5, b=7, setcc=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, result=12, ovf=0, ZF=0, SF=0, OF=0.
REQ-028 Both valid continuously, rsp_ready=1, FIRST_PRIO=0 -> rsp_id sequence 0,1,0,1 on consecutive cycles.
REQ-029 req1 add a=0x7FFFFFFFFFFFFFFF, b=1, setcc=1 -> result=0x8000000000000000, ovf=1, SF=1, OF=1, ZF=0.
REQ-030 req0 and a=0xF0, b=0x3C, then rsp_ready=0 for 3 cycles with req1 valid -> result 0x30 held 3 cycles, req1_ready=0; on rsp_ready=1, req1 accepted the same cycle.
REQ-031 req0 xor a=b=0xAA, setcc=0 after a setcc result with ZF=0 -> result=0, ZF stays 0.
REQ-032 rst_n=0 while FULL with both valid -> next cycle rsp_valid=0, both _ready=0, cc reset values.
